// File: rtl/pipe_pkg.sv
// +---------------------------------------------------------------------------+
// | pipe_pkg : shared defaults and the occupancy-width helper for pipe_flopenr |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

    localparam int PIPE_WIDTH_DEF = 28;
    localparam int PIPE_DEPTH_DEF = 3;

    // Width needed to count 0..depth valid entries.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_stage.sv
// +---------------------------------------------------------------------------+
// | pipe_stage : one valid+data register with load enable and flush          |
// | Revision   : 1.0                                                          |
// +---------------------------------------------------------------------------+
`default_nettype none

module pipe_stage #(
    parameter int WIDTH = 28
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Data only moves with the enable; flush kills the valid bit but leaves data stale.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = in_valid;
            data_d  = in_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule : pipe_stage

`default_nettype wire

// File: rtl/pipe_flopenr.sv
// +---------------------------------------------------------------------------+
// | pipe_flopenr : DEPTH-stage bubble-collapsing valid/ready register pipe     |
// |                optional occupancy counter port under macro PIPE_OCC_EN    |
// | Revision     : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

module pipe_flopenr
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEF,
    parameter int DEPTH = PIPE_DEPTH_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready
`ifdef PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0]   occ
`endif
);

    logic             stage_valid [DEPTH];
    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_ready [DEPTH+1];

    // Ready ripples from the output side back to the input side in one pass.
    always_comb begin
        stage_ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            stage_ready[i] = !stage_valid[i] || stage_ready[i+1];
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             stage_in_valid;
            logic [WIDTH-1:0] stage_in_data;

            if (i == 0) begin : g_head
                assign stage_in_valid = in_valid;
                assign stage_in_data  = in_data;
            end else begin : g_body
                assign stage_in_valid = stage_valid[i-1];
                assign stage_in_data  = stage_data[i-1];
            end

            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clock    (clock),
                .reset    (reset),
                .flush    (flush),
                .en       (stage_ready[i]),
                .in_valid (stage_in_valid),
                .in_data  (stage_in_data),
                .valid    (stage_valid[i]),
                .data     (stage_data[i])
            );
        end
    endgenerate

    assign in_ready  = stage_ready[0] && reset;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

`ifdef PIPE_OCC_EN
    localparam int                 OCC_W     = occ_width(DEPTH);
    localparam logic [OCC_W-1:0]   C_OCC_ONE = OCC_W'(1);

    logic             accept;
    logic             retire;
    logic [OCC_W-1:0] occ_d;
    logic [OCC_W-1:0] occ_q;

    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !retire) begin
            occ_d = occ_q + C_OCC_ONE;
        end else if (!accept && retire) begin
            occ_d = occ_q - C_OCC_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule : pipe_flopenr

`default_nettype wire
